// File: rtl/sysarr_feeder.sv
// Operand buffer and job sequencer for a 4x4 systolic multiply array: feeds skewed
// X/Y wavefronts, waits for job completion, then streams the 16 results row-major.
module sysarr_feeder #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         wr_sel,
  input  logic [3:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         arr_g_rst,
  output logic         arr_data_ready,
  output logic [127:0] arr_a,
  output logic [127:0] arr_b,
  output logic [3:0]   arr_index,
  input  logic [31:0]  arr_data,
  input  logic         arr_out_ready,
  input  logic         arr_job_done,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_data,
  output logic         res_last
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_WAIT,
    S_DRAIN,
    S_ABORT
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [3:0]          k_q, k_d;
  logic [31:0]         x_q [16];
  logic [31:0]         x_d [16];
  logic [31:0]         y_q [16];
  logic [31:0]         y_d [16];

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                g_rst_q, g_rst_d;
  logic                feed_q, feed_d;
  logic [127:0]        a_q, a_d;
  logic [127:0]        b_q, b_d;
  logic                res_valid_q, res_valid_d;
  logic [31:0]         res_data_q, res_data_d;
  logic                res_last_q, res_last_d;

  logic                accept;
  logic                capture;
  logic [3:0]          lane_k;

  // Next-state and datapath control.
  // NOTE: every signal gets a default at the top so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    wait_d      = wait_q;
    k_d         = k_q;
    x_d         = x_q;
    y_d         = y_q;
    err_d       = err_q;
    done_d      = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_last_d  = res_last_q;
    accept      = res_valid_q && res_ready;
    capture     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          if (wr_sel) y_d[wr_addr] = wr_data;
          else        x_d[wr_addr] = wr_data;
        end
        if (start) begin
          state_d = S_CLEAR;
          err_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        step_d  = 3'd0;
      end
      S_FEED: begin
        if (step_q == 3'd6) begin
          state_d = S_WAIT;
          wait_d  = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_WAIT: begin
        if (arr_job_done) begin
          state_d = S_DRAIN;
          k_d     = 4'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ABORT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DRAIN: begin
        // The output register may refill in the same cycle its beat is taken,
        // but never once the final beat is already waiting.
        capture = (!res_valid_q || res_ready) && arr_out_ready &&
                  !(res_valid_q && res_last_q);
        if (accept) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
        end
        if (capture) begin
          res_valid_d = 1'b1;
          res_data_d  = arr_data;
          res_last_d  = (k_q == 4'd15);
          if (k_q != 4'd15) k_d = k_q + 4'd1;
        end
        if (accept && res_last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          k_d     = 4'd0;
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    g_rst_d = (state_d == S_CLEAR);
    feed_d  = (state_d == S_FEED);
  end

  // Skewed wavefronts: at step t, column lane j carries Y[t-j][j] and row
  // lane i carries X[i][t-i]; lane_k wraps high when t < lane, failing the range test.
  always_comb begin
    a_d    = '0;
    b_d    = '0;
    lane_k = '0;
    if (feed_d) begin
      for (int l = 0; l < 4; l++) begin
        lane_k = {1'b0, step_d} - 4'(l);
        if (lane_k < 4'd4) begin
          a_d[32*l +: 32] = y_q[{lane_k[1:0], 2'(l)}];
          b_d[32*l +: 32] = x_q[{2'(l), lane_k[1:0]}];
        end
      end
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      wait_q      <= '0;
      k_q         <= '0;
      // NOTE: the operand files are cleared on reset because a reset must leave both matrices reading zero.
      x_q         <= '{default: '0};
      y_q         <= '{default: '0};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      g_rst_q     <= 1'b0;
      feed_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      wait_q      <= wait_d;
      k_q         <= k_d;
      x_q         <= x_d;
      y_q         <= y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      g_rst_q     <= g_rst_d;
      feed_q      <= feed_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign arr_g_rst      = g_rst_q;
  assign arr_data_ready = feed_q;
  assign arr_a          = a_q;
  assign arr_b          = b_q;
  assign arr_index      = k_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_last       = res_last_q;

endmodule
